// File: rtl/otter_intr_ctrl_if.sv
// Bundles the interrupt lines, CU handshake and MMIO configuration port of
// the OTTER interrupt controller; the controller takes the slave side.
interface otter_intr_ctrl_if #(
    parameter int NUM_SRC = 8,
    parameter int XLEN    = 32,
    parameter int IDW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
    logic [NUM_SRC-1:0] intr_in;
    logic               mie;
    logic               int_ack;
    logic               int_clr;
    logic               cfg_wr;
    logic [1:0]         cfg_addr;
    logic [XLEN-1:0]    cfg_wdata;
    logic [XLEN-1:0]    cfg_rdata;
    logic               int_req;
    logic [IDW-1:0]     int_id;
    logic [XLEN-1:0]    int_vector;
    logic               int_active;

    modport master (
        output intr_in, mie, int_ack, int_clr, cfg_wr, cfg_addr, cfg_wdata,
        input  cfg_rdata, int_req, int_id, int_vector, int_active
    );

    modport slave (
        input  intr_in, mie, int_ack, int_clr, cfg_wr, cfg_addr, cfg_wdata,
        output cfg_rdata, int_req, int_id, int_vector, int_active
    );
endinterface

// File: rtl/otter_intr_ctrl.sv
// Multi-source interrupt controller for the OTTER multicycle CPU: synchronised,
// maskable, lowest-index-first prioritised sources with a vectored target.
module otter_intr_ctrl #(
    parameter int                 NUM_SRC     = 8,
    parameter int                 XLEN        = 32,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = '1,
    parameter logic [XLEN-1:0]    VBASE_RST   = '0
) (
    input logic              clk,
    input logic              rst,
    otter_intr_ctrl_if.slave bus
);
    localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state, next_state;
    logic [NUM_SRC-1:0] sync_ff [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_hist;
    logic [NUM_SRC-1:0] sync_level;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr_mask;
    logic [XLEN-1:0]    vbase;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     int_id;
    logic               int_req;
    logic               int_active;
    logic               any_eligible;
    logic [XLEN-1:0]    status;
    logic [XLEN-1:0]    rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
            sync_hist <= '0;
        end else begin
            sync_ff[0] <= bus.intr_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
            sync_hist <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign sync_level = sync_ff[SYNC_STAGES-1];
    assign rise       = sync_level & ~sync_hist & EDGE_MASK;

    // Level sources bypass the pending register and mirror the synchronised line.
    assign pending  = (pend_q & EDGE_MASK) | (sync_level & ~EDGE_MASK);
    assign eligible = pending & enable;

    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = IDW'(i);
        end
    end

    assign any_eligible = |eligible;

    always_comb begin
        clr_mask = '0;
        if (bus.cfg_wr && bus.cfg_addr == 2'd1) clr_mask = bus.cfg_wdata[NUM_SRC-1:0];
        if (state == REQ && bus.int_ack) clr_mask = clr_mask | (NUM_SRC'(1) << int_id);
    end

    // A new edge in the same cycle as a clear leaves the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= ((pend_q & ~clr_mask) | rise) & EDGE_MASK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable <= '0;
            vbase  <= VBASE_RST & ALIGN_MASK;
        end else if (bus.cfg_wr) begin
            if (bus.cfg_addr == 2'd0) enable <= bus.cfg_wdata[NUM_SRC-1:0];
            if (bus.cfg_addr == 2'd2) vbase  <= bus.cfg_wdata & ALIGN_MASK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.mie && any_eligible) next_state = REQ;
            REQ: begin
                if (bus.int_ack)                            next_state = SERVICE;
                else if (!bus.mie || !eligible[int_id])     next_state = IDLE;
            end
            SERVICE: if (bus.int_clr) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        int_req    = (state == REQ);
        int_active = (state == SERVICE);
    end

    // The ID is captured once on entry to REQ and cleared whenever we fall back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    int_id <= '0;
        else if (state == IDLE && next_state == REQ) int_id <= winner;
        else if (next_state == IDLE)                int_id <= '0;
    end

    always_comb begin
        status           = XLEN'(int_id);
        status[XLEN-1]   = int_active;
        status[XLEN-2]   = int_req;
    end

    always_comb begin
        rdata = '0;
        case (bus.cfg_addr)
            2'd0: rdata = XLEN'(enable);
            2'd1: rdata = XLEN'(pending);
            2'd2: rdata = vbase;
            2'd3: rdata = status;
            default: rdata = '0;
        endcase
    end

    assign bus.cfg_rdata  = rdata;
    assign bus.int_req    = int_req;
    assign bus.int_active = int_active;
    assign bus.int_id     = int_id;
    assign bus.int_vector = vbase + XLEN'({int_id, 2'b00});
endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Scenario-based and randomised check of otter_intr_ctrl against a behavioural model.
module tb_otter_intr_ctrl;
    localparam int          NSRC  = 8;
    localparam int          SYNC  = 2;
    localparam logic [7:0]  EDGE  = 8'hBF;
    localparam logic [31:0] VRST  = 32'h0000_0043;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    otter_intr_ctrl_if #(.NUM_SRC(NSRC), .XLEN(32)) bus ();

    otter_intr_ctrl #(
        .NUM_SRC(NSRC), .XLEN(32), .SYNC_STAGES(SYNC),
        .EDGE_MASK(EDGE), .VBASE_RST(VRST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: input sample history, edge-pending bits, enable, vbase, state 0/1/2 = idle/req/service.
    logic [7:0]  hist [0:SYNC];
    logic [7:0]  m_pend_e;
    logic [7:0]  m_en;
    logic [31:0] m_vbase;
    logic [2:0]  m_id;
    int          m_state;

    task automatic model_reset();
        for (int i = 0; i <= SYNC; i++) hist[i] = 8'h00;
        m_pend_e = 8'h00;
        m_en     = 8'h00;
        m_vbase  = VRST & 32'hFFFF_FFFC;
        m_id     = 3'd0;
        m_state  = 0;
    endtask

    function automatic logic [7:0] m_pending();
        return m_pend_e | (hist[SYNC-1] & ~EDGE);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0: return {24'h0, m_en};
            2'd1: return {24'h0, m_pending()};
            2'd2: return m_vbase;
            default: return {(m_state == 2), (m_state == 1), 27'h0, m_id};
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied, then clock the DUT.
    task automatic step();
        logic [7:0]  rise, elig, clr, n_pend, n_en;
        logic [31:0] n_vbase;
        logic [2:0]  n_id;
        int          win, n_state;
        rise = hist[SYNC-1] & ~hist[SYNC] & EDGE;
        elig = m_pending() & m_en;
        win  = -1;
        for (int i = 0; i < NSRC; i++) if (elig[i] && win < 0) win = i;
        clr = 8'h00;
        if (bus.cfg_wr && bus.cfg_addr == 2'd1) clr = bus.cfg_wdata[7:0];
        n_state = m_state;
        n_id    = m_id;
        case (m_state)
            0: if (bus.mie && win >= 0) begin n_state = 1; n_id = 3'(win); end
            1: begin
                if (bus.int_ack) begin
                    clr = clr | (8'h01 << m_id);
                    n_state = 2;
                end else if (!bus.mie || !elig[m_id]) begin
                    n_state = 0;
                    n_id = 3'd0;
                end
            end
            default: if (bus.int_clr) begin n_state = 0; n_id = 3'd0; end
        endcase
        n_pend  = ((m_pend_e & ~clr) | rise) & EDGE;
        n_en    = (bus.cfg_wr && bus.cfg_addr == 2'd0) ? bus.cfg_wdata[7:0] : m_en;
        n_vbase = (bus.cfg_wr && bus.cfg_addr == 2'd2) ? (bus.cfg_wdata & 32'hFFFF_FFFC) : m_vbase;
        for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bus.intr_in;
        @(posedge clk);
        #1;
        m_pend_e = n_pend;
        m_en     = n_en;
        m_vbase  = n_vbase;
        m_id     = n_id;
        m_state  = n_state;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        bus.cfg_wr = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
        step();
        bus.cfg_wr = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] m);
        bus.intr_in = m;
        step();
        bus.intr_in = 8'h00;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        bus.cfg_addr = a;
        #1;
        d = bus.cfg_rdata;
    endtask

    task automatic applyStimulus_idle();
        bus.intr_in = 8'h00; bus.mie = 1'b0; bus.int_ack = 1'b0; bus.int_clr = 1'b0;
        bus.cfg_wr = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        checks++; if (bus.int_req !== 1'b0) $display("[TB] FAIL reset_req got %b want 0", bus.int_req); else passed++;
        checks++; if (bus.int_active !== 1'b0) $display("[TB] FAIL reset_active got %b want 0", bus.int_active); else passed++;
        checks++; if (bus.int_vector !== 32'h40) $display("[TB] FAIL reset_vector got %h want 00000040", bus.int_vector); else passed++;
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), r);
            checks++;
            if (r !== ((a == 2) ? 32'h40 : 32'h0)) $display("[TB] FAIL reset_reg%0d got %h want %h", a, r, (a == 2) ? 32'h40 : 32'h0);
            else passed++;
        end
    endtask

    task automatic test_single();
        logic [31:0] r;
        write_reg(2'd0, 32'hFFFF_FFFF);
        write_reg(2'd2, 32'h0000_0100);
        bus.mie = 1'b1;
        pulse(8'h08); step(); step();
        read_reg(2'd1, r);
        checks++; if (r !== 32'h08) $display("[TB] FAIL single_pending got %h want 00000008", r); else passed++;
        checks++; if (bus.int_req !== 1'b0) $display("[TB] FAIL single_req_early got %b want 0", bus.int_req); else passed++;
        step();
        checks++; if (bus.int_req !== 1'b1) $display("[TB] FAIL single_req got %b want 1", bus.int_req); else passed++;
        checks++; if (bus.int_id !== 3'd3) $display("[TB] FAIL single_id got %0d want 3", bus.int_id); else passed++;
        checks++; if (bus.int_vector !== 32'h10C) $display("[TB] FAIL single_vector got %h want 0000010c", bus.int_vector); else passed++;
        read_reg(2'd3, r);
        checks++; if (r !== 32'h4000_0003) $display("[TB] FAIL single_status_req got %h want 40000003", r); else passed++;
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        read_reg(2'd1, r);
        checks++; if (r !== 32'h0) $display("[TB] FAIL single_ack_pending got %h want 0", r); else passed++;
        checks++; if (bus.int_active !== 1'b1) $display("[TB] FAIL single_active got %b want 1", bus.int_active); else passed++;
        bus.int_clr = 1'b1; step(); bus.int_clr = 1'b0;
        read_reg(2'd3, r);
        checks++; if (r !== 32'h0) $display("[TB] FAIL single_status_end got %h want 0", r); else passed++;
    endtask

    task automatic test_priority();
        logic [31:0] r;
        pulse(8'h24); step(); step();
        read_reg(2'd1, r);
        checks++; if (r !== 32'h24) $display("[TB] FAIL prio_pending got %h want 00000024", r); else passed++;
        step();
        checks++; if (bus.int_id !== 3'd2) $display("[TB] FAIL prio_first_id got %0d want 2", bus.int_id); else passed++;
        checks++; if (bus.int_vector !== 32'h108) $display("[TB] FAIL prio_first_vec got %h want 00000108", bus.int_vector); else passed++;
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        bus.int_clr = 1'b1; step(); bus.int_clr = 1'b0;
        checks++; if (bus.int_req !== 1'b0) $display("[TB] FAIL prio_gap_req got %b want 0", bus.int_req); else passed++;
        step();
        checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd5) $display("[TB] FAIL prio_second req/id got %b/%0d want 1/5", bus.int_req, bus.int_id); else passed++;
        checks++; if (bus.int_vector !== 32'h114) $display("[TB] FAIL prio_second_vec got %h want 00000114", bus.int_vector); else passed++;
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        bus.int_clr = 1'b1; step(); bus.int_clr = 1'b0;
    endtask

    task automatic test_no_nesting();
        logic [31:0] r;
        pulse(8'h10); step(); step(); step();
        checks++; if (bus.int_id !== 3'd4) $display("[TB] FAIL nest_id4 got %0d want 4", bus.int_id); else passed++;
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        pulse(8'h01); step(); step();
        read_reg(2'd1, r);
        checks++; if (r !== 32'h01) $display("[TB] FAIL nest_pending got %h want 00000001", r); else passed++;
        checks++; if (bus.int_req !== 1'b0 || bus.int_active !== 1'b1) $display("[TB] FAIL nest_service req/active got %b/%b want 0/1", bus.int_req, bus.int_active); else passed++;
        bus.int_clr = 1'b1; step(); bus.int_clr = 1'b0;
        checks++; if (bus.int_req !== 1'b0) $display("[TB] FAIL nest_clr_req got %b want 0", bus.int_req); else passed++;
        step();
        checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd0) $display("[TB] FAIL nest_rearb req/id got %b/%0d want 1/0", bus.int_req, bus.int_id); else passed++;
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        bus.int_clr = 1'b1; step(); bus.int_clr = 1'b0;
    endtask

    task automatic test_withdraw();
        logic [31:0] r;
        pulse(8'h02); step(); step(); step();
        checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd1) $display("[TB] FAIL wd_req req/id got %b/%0d want 1/1", bus.int_req, bus.int_id); else passed++;
        bus.mie = 1'b0; step();
        read_reg(2'd1, r);
        checks++; if (bus.int_req !== 1'b0) $display("[TB] FAIL wd_drop_req got %b want 0", bus.int_req); else passed++;
        checks++; if (r !== 32'h02) $display("[TB] FAIL wd_pending got %h want 00000002", r); else passed++;
        bus.mie = 1'b1; step();
        checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd1) $display("[TB] FAIL wd_reissue req/id got %b/%0d want 1/1", bus.int_req, bus.int_id); else passed++;
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        bus.int_clr = 1'b1; step(); bus.int_clr = 1'b0;
    endtask

    task automatic test_pending_writes();
        logic [31:0] r;
        bus.mie = 1'b0;
        pulse(8'h01); step();
        write_reg(2'd1, 32'h01);
        read_reg(2'd1, r);
        checks++; if (r !== 32'h01) $display("[TB] FAIL w1c_set_wins got %h want 00000001", r); else passed++;
        write_reg(2'd1, 32'h01);
        read_reg(2'd1, r);
        checks++; if (r !== 32'h00) $display("[TB] FAIL w1c_clear got %h want 0", r); else passed++;
        bus.intr_in = 8'h40; step(); step();
        read_reg(2'd1, r);
        checks++; if (r !== 32'h40) $display("[TB] FAIL level_high got %h want 00000040", r); else passed++;
        write_reg(2'd1, 32'hFF);
        read_reg(2'd1, r);
        checks++; if (r !== 32'h40) $display("[TB] FAIL level_w1c got %h want 00000040", r); else passed++;
        bus.intr_in = 8'h00; step(); step();
        read_reg(2'd1, r);
        checks++; if (r !== 32'h00) $display("[TB] FAIL level_low got %h want 0", r); else passed++;
        bus.mie = 1'b1;
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        pulse(8'h04); step(); step(); step();
        checks++; if (bus.int_req !== 1'b1) $display("[TB] FAIL ar_pre_req got %b want 1", bus.int_req); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.int_req !== 1'b0 || bus.int_id !== 3'd0) $display("[TB] FAIL ar_req_id got %b/%0d want 0/0", bus.int_req, bus.int_id); else passed++;
        read_reg(2'd1, r);
        checks++; if (r !== 32'h0) $display("[TB] FAIL ar_pending got %h want 0", r); else passed++;
        read_reg(2'd0, r);
        checks++; if (r !== 32'h0) $display("[TB] FAIL ar_enable got %h want 0", r); else passed++;
        read_reg(2'd2, r);
        checks++; if (r !== 32'h40) $display("[TB] FAIL ar_vbase got %h want 00000040", r); else passed++;
        model_reset();
        applyStimulus_idle();
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [31:0] exp;
        write_reg(2'd0, $urandom);
        write_reg(2'd2, $urandom);
        for (int n = 0; n < 1500; n++) begin
            bus.intr_in   = 8'($urandom & $urandom & $urandom);
            bus.mie       = ($urandom_range(0, 15) != 0);
            bus.int_ack   = ($urandom_range(0, 2) == 0);
            bus.int_clr   = ($urandom_range(0, 3) == 0);
            bus.cfg_wr    = ($urandom_range(0, 7) == 0);
            bus.cfg_addr  = 2'($urandom_range(0, 3));
            bus.cfg_wdata = $urandom;
            step();
            bus.cfg_wr = 1'b0;
            exp = exp_rd(bus.cfg_addr);
            checks++; if (bus.int_req !== (m_state == 1)) $display("[TB] FAIL rnd_req cyc %0d got %b want %b", n, bus.int_req, (m_state == 1)); else passed++;
            checks++; if (bus.int_active !== (m_state == 2)) $display("[TB] FAIL rnd_active cyc %0d got %b want %b", n, bus.int_active, (m_state == 2)); else passed++;
            checks++; if (bus.int_id !== m_id) $display("[TB] FAIL rnd_id cyc %0d got %0d want %0d", n, bus.int_id, m_id); else passed++;
            checks++; if (bus.int_vector !== m_vbase + 32'(m_id) * 4) $display("[TB] FAIL rnd_vector cyc %0d got %h want %h", n, bus.int_vector, m_vbase + 32'(m_id) * 4); else passed++;
            checks++; if (bus.cfg_rdata !== exp) $display("[TB] FAIL rnd_rdata cyc %0d addr %0d got %h want %h", n, bus.cfg_addr, bus.cfg_rdata, exp); else passed++;
        end
    endtask

    initial begin
        applyStimulus_idle();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step();
        test_reset();
        test_single();
        test_priority();
        test_no_nesting();
        test_withdraw();
        test_pending_writes();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/otter_intr_ctrl.md
Name: otter_intr_ctrl

Overview:
- Parametrised multi-source interrupt controller for the OTTER multicycle CPU.
- Replaces the single-line INTR/prev_INT latch with NUM_SRC synchronised, maskable, prioritised sources and a per-source vectored target.
- Sits between external interrupt lines, the CU FSM (request/take/clear handshake) and the MMIO bus (configuration registers).

Parameters:
- NUM_SRC, 8: number of interrupt sources, 1..32.
- XLEN, 32: data and vector width.
- SYNC_STAGES, 2: input synchroniser depth, minimum 2.
- EDGE_MASK, all ones: bit i = 1 makes source i rising-edge; bit i = 0 makes it level.
- VBASE_RST, 0: reset value of VBASE.

Ports:
- CLK, in, 1: system clock, rising edge.
- RESET, in, 1: asynchronous, active-high reset.
- INTR_IN, in, NUM_SRC: raw external interrupt lines, asynchronous to CLK.
- MIE, in, 1: global interrupt enable from the CSR file.
- INT_ACK, in, 1: CU FSM is taking the interrupt (intTaken).
- INT_CLR, in, 1: handler has returned (mret / intCLR).
- CFG_WR, in, 1: MMIO register write strobe.
- CFG_ADDR, in, 2: register select (0 ENABLE, 1 PENDING, 2 VBASE, 3 STATUS).
- CFG_WDATA, in, XLEN: write data.
- CFG_RDATA, out, XLEN: combinational read data for CFG_ADDR.
- INT_REQ, out, 1: interrupt request to the CU FSM.
- INT_ID, out, clog2(NUM_SRC) (minimum 1): ID of the latched source.
- INT_VECTOR, out, XLEN: handler address, VBASE + INT_ID*4.
- INT_ACTIVE, out, 1: a handler is in service.

Behaviour:
- Reset: asynchronous. All synchroniser flops, PENDING, ENABLE, INT_REQ, INT_ID and INT_ACTIVE go to 0; VBASE goes to VBASE_RST with bits [1:0] forced to 0; state goes to IDLE. Reset mid-request or mid-service drops everything and nothing is retained.
- Synchroniser: each INTR_IN bit passes through SYNC_STAGES flops. Edge sources also keep one history flop, so a rising edge is detected SYNC_STAGES+1 cycles after the input changes.
- Pending, edge source: set on a detected rising edge; cleared by a write-1 to PENDING or by INT_ACK while that source is latched. If a set and a clear hit the same bit in the same cycle, the set wins.
- Pending, level source: the bit equals the synchronised level; writes have no effect.
- Pending bits are captured whatever ENABLE holds. Eligible = PENDING & ENABLE.
- Priority: the lowest eligible index wins.
- State IDLE:
  - INT_REQ = 0, INT_ACTIVE = 0.
  - If MIE and eligible is nonzero: latch INT_ID = winner and go to REQ.
  - INT_REQ rises on the next edge, one cycle after eligibility is seen.
- State REQ:
  - INT_REQ = 1. INT_ID and INT_VECTOR are held stable; a higher-priority arrival does not replace the latched ID.
  - INT_ACK = 1: clear the latched pending bit if the source is edge type, then go to SERVICE.
  - MIE = 0, or the latched source is no longer eligible (disabled, or level source deasserted), with no INT_ACK: go to IDLE with pending preserved.
  - If INT_ACK and withdrawal happen in the same cycle, INT_ACK wins.
- State SERVICE:
  - INT_REQ = 0, INT_ACTIVE = 1. There is no nesting; new events only set PENDING.
  - INT_CLR: go to IDLE. Re-arbitration happens in IDLE on the following cycle.
- INT_CLR in IDLE or REQ is ignored. INT_ACK in IDLE or SERVICE is ignored.
- INT_VECTOR = VBASE + {INT_ID, 2'b00}, modulo 2^XLEN, combinational from the registered INT_ID and VBASE.
- Register writes:
  - ENABLE: takes CFG_WDATA[NUM_SRC-1:0]; upper bits are ignored.
  - PENDING: write-1-to-clear, edge sources only.
  - VBASE: takes CFG_WDATA with bits [1:0] forced to 0.
  - STATUS: read-only.
  - All writes are legal in any state and take effect on the next edge.
- Register reads:
  - ENABLE and PENDING read back zero-extended.
  - STATUS reads {INT_ACTIVE, INT_REQ, zero-extended INT_ID}, with INT_ACTIVE at bit 31 and INT_REQ at bit 30.

Test Plan:
- Reset, ENABLE = 0xFF, VBASE = 0x100, MIE = 1, pulse INTR_IN[3] for 1 cycle -> PENDING[3] = 1 after 3 cycles. Next cycle INT_REQ = 1, INT_ID = 3, INT_VECTOR = 0x10C. INT_ACK -> PENDING[3] = 0, INT_ACTIVE = 1. INT_CLR -> IDLE, STATUS = 0.
- Sources 5 and 2 rise in the same cycle -> INT_ID = 2 first. After ACK and CLR -> INT_ID = 5, vector VBASE + 0x14.
- While in SERVICE on source 4, source 0 rises -> INT_REQ stays 0 and PENDING[0] = 1. INT_CLR -> INT_REQ = 1, INT_ID = 0 two cycles later.
- In REQ for source 1, drop MIE -> back to IDLE, INT_REQ = 0, PENDING[1] still 1. Raise MIE -> request reissues with INT_ID = 1.
- Same cycle: write PENDING = 0x01 and a new edge on source 0 -> PENDING[0] remains 1. Write PENDING = 0x01 with no edge -> bit clears. Level source (EDGE_MASK[6] = 0) held high -> PENDING[6] is unaffected by writes.
- Assert RESET asynchronously mid-REQ -> INT_REQ, INT_ID, PENDING and ENABLE read 0 immediately. VBASE reads VBASE_RST.
